// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked add/subtract unit: opcode and FSM encodings
// plus the chunk-count helper used to size the sequencer.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int calc_n(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple slice; the sequencer feeds it one operand chunk per cycle.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] total_s;

    assign total_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign s       = total_s[CHUNK-1:0];
    assign cout    = total_s[CHUNK];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/sub/accumulate: one CHUNK-wide slice per cycle, LSB first,
// with the architectural result registers updated only on completion.
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = calc_n(WIDTH, CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_width_check
        $error("chunked_addsub: WIDTH must be an integer multiple of CHUNK");
    end

    state_e           state_r;
    state_e           state_s;
    op_e              op_s;
    logic             load_s;
    logic             step_s;
    logic             finish_s;
    logic             last_s;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] ymux_s;
    logic [WIDTH-1:0] part_r;
    logic [WIDTH-1:0] part_next_s;
    logic             cy_r;
    logic             a_msb_r;
    logic             y_msb_r;
    logic             clr_pend_r;
    logic [CHUNK-1:0] chunk_sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ovf_r;

    assign op_s   = op_e'(op);
    assign last_s = (idx_r == IW'(N - 1));

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (a_r[CHUNK-1:0]),
        .y    (y_r[CHUNK-1:0]),
        .cin  (cy_r),
        .s    (chunk_sum_s),
        .cout (cout_s)
    );

    // New chunk enters at the top so the finished word ends up LSB-aligned.
    assign part_next_s = (part_r >> CHUNK) | (WIDTH'(chunk_sum_s) << (WIDTH - CHUNK));
    assign ovf_s       = (a_msb_r == y_msb_r) && (part_next_s[WIDTH-1] != a_msb_r);

    // Operand B selection at launch: inverted for SUB, current result for ACC.
    always_comb begin
        ymux_s = b;
        case (op_s)
            OP_SUB:  ymux_s = ~b;
            OP_ACC:  ymux_s = sum_r;
            default: ymux_s = b;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; CLR completes without entering RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s && (op_s != OP_CLR)) state_s = ST_RUN;
                else                            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_IDLE;
                else        state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode; a pending CLR blocks a new launch for its one cycle.
    always_comb begin
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !clr_pend_r) load_s = 1'b1;
                else                      load_s = 1'b0;
            end
            ST_RUN: begin
                step_s   = 1'b1;
                finish_s = last_s;
            end
            default: begin
                load_s   = 1'b0;
                step_s   = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Operand shift registers, chained carry and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= {WIDTH{1'b0}};
            y_r        <= {WIDTH{1'b0}};
            part_r     <= {WIDTH{1'b0}};
            cy_r       <= 1'b0;
            idx_r      <= {IW{1'b0}};
            a_msb_r    <= 1'b0;
            y_msb_r    <= 1'b0;
            clr_pend_r <= 1'b0;
        end else begin
            clr_pend_r <= load_s && (op_s == OP_CLR);
            if (load_s) begin
                a_r     <= a;
                y_r     <= ymux_s;
                part_r  <= {WIDTH{1'b0}};
                cy_r    <= (op_s == OP_SUB);
                idx_r   <= {IW{1'b0}};
                a_msb_r <= a[WIDTH-1];
                y_msb_r <= ymux_s[WIDTH-1];
            end else if (step_s) begin
                a_r    <= a_r >> CHUNK;
                y_r    <= y_r >> CHUNK;
                part_r <= part_next_s;
                cy_r   <= cout_s;
                idx_r  <= idx_r + IW'(1);
            end else begin
                a_r    <= a_r;
                y_r    <= y_r;
                part_r <= part_r;
                cy_r   <= cy_r;
                idx_r  <= idx_r;
            end
        end
    end

    // Architectural outputs: change only on completion or CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= finish_s | clr_pend_r;
            if (finish_s) begin
                sum_r   <= part_next_s;
                carry_r <= cout_s;
                ovf_r   <= ovf_s;
            end else if (clr_pend_r) begin
                sum_r   <= {WIDTH{1'b0}};
                carry_r <= 1'b0;
                ovf_r   <= 1'b0;
            end else begin
                sum_r   <= sum_r;
                carry_r <= carry_r;
                ovf_r   <= ovf_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign carry    = carry_r;
    assign overflow = ovf_r;

endmodule
